axis_coincidence_reader: RTL and testbench
==========================================

// Module: axis_coincidence_reader
// PURPOSE
// Parametrised coincidence detector for DET_WIDTH detector lines split into GROUPS equal groups. Sequence:
//   synchronise lines into aclk; open a programmable window on first hit; OR hits over the window;
//   count groups hit; emit one AXI4-Stream beat {first-hit timestamp, OR'd hits} if count >= threshold,
//   then hold off for a programmable dead time. Sits between detector front-end pins and the event DMA/FIFO.
// PARAMETERS
// DET_WIDTH   64  detector lines; must be a multiple of GROUPS
// GROUPS      4   coincidence groups, each DET_WIDTH/GROUPS contiguous lines, group 0 = LSBs
// TIME_WIDTH  64  free-running timestamp width
// WIN_WIDTH   8   width of cfg_window
// DEAD_WIDTH  16  width of cfg_dead
// SYNC_STAGES 3   synchroniser flops on det_data (>=2)
// PORTS
// aclk           in   1                       clock
// areset         in   1                       reset, asynchronous, active-high
// det_data       in   DET_WIDTH               asynchronous detector lines
// cfg_window     in   WIN_WIDTH               extra window cycles after first hit
// cfg_threshold  in   SW=$clog2(GROUPS+1)     min groups hit
// cfg_dead       in   DEAD_WIDTH              dead-time cycles after each decision
// m_axis_tdata   out  TIME_WIDTH+DET_WIDTH    {timestamp, hits}
// m_axis_tvalid  out  1
// m_axis_tready  in   1
// BEHAVIOUR
// - Reset (async assert, sync release): all regs 0, state IDLE, m_axis_tvalid=0, m_axis_tdata=0; timer restarts at 0.
// - sync = det_data after SYNC_STAGES flops (each reset to 0); all decisions below use sync.
// - timer: +1 every cycle, wraps modulo 2^TIME_WIDTH, runs in every state.
// - IDLE:   data<=sync; if |sync: ts<=timer, cnt<=0, win<=cfg_window; go WINDOW if cfg_window!=0, else REDUCE.
// - WINDOW: data<=data|sync; cnt<=cnt+1; when cnt+1==win go REDUCE. Total window = 1+win cycles.
// - REDUCE: grp[g] <= |data[g*GW +: GW], GW=DET_WIDTH/GROUPS.
// - COUNT:  sum <= popcount(grp), SW bits, no overflow possible.
// - DECIDE: sum>=cfg_threshold -> SEND with m_axis_tvalid<=1; else -> DEAD. cfg_threshold=0 always passes.
// - SEND:   tdata={ts,data} stable while tvalid=1; on tvalid&tready: tvalid<=0, go DEAD. No timeout.
// - DEAD:   sync ignored; stays cfg_dead cycles (counter loaded on entry), then IDLE; cfg_dead=0 -> one DEAD cycle.
// - Hits arriving outside IDLE/WINDOW are dropped.
// - Latency, first hit at sync to tvalid: 1+win window + REDUCE + COUNT + DECIDE = win+4 cycles.
// - cfg_* sampled where used (window at IDLE exit, threshold in DECIDE, dead at DEAD entry); changes mid-event
//   affect only later uses.
// - timer wrap inside a window is harmless: ts is latched once.
// - areset mid-event: event discarded; tvalid falls immediately, even if tready was 0.
// CONFIGURATION
// - LOST_CNTR_EN defined: extra output sts_lost [31:0].
//   +1 each cycle in SEND or DEAD where |sync; saturates at 32'hFFFFFFFF; reset to 0.
// - LOST_CNTR_EN undefined: port and counter absent; behaviour otherwise identical.
// TESTING
// 1 det_data=64'h1 for 1 cycle, cfg_window=3, cfg_threshold=1
//   -> one beat, tdata[63:0]=64'h1, ts = timer value at first sync hit, tvalid win+4=7 cycles later.
// 2 det_data bit0 then bit20 two cycles later, window=3, threshold=2
//   -> beat with hits=64'h0010_0001; same with window=1 -> no beat.
// 3 bits 0,16,32,48 set together, threshold=4 -> beat; threshold=5 -> no beat; threshold=0 with any hit -> beat.
// 4 tready=0 for 20 cycles during SEND
//   -> tvalid/tdata held constant, one beat on release; LOST_CNTR_EN: hits during hold raise sts_lost.
// 5 cfg_dead=10, hit pulse every cycle
//   -> successive beats spaced exactly win+4+1+10 cycles apart with tready=1; cfg_dead=0 -> spacing win+6.
// 6 assert areset while tvalid=1 and tready=0
//   -> tvalid=0 same cycle; after release timer restarts at 0 and next hit is detected normally.

Source files
------------

// File: rtl/axis_coincidence_reader.sv
// Coincidence detector: synchronised hit lines, windowed OR, group count, one AXI4-Stream beat per event.
// Optional build macro LOST_CNTR_EN adds the sts_lost counter of hits dropped during SEND/DEAD.
module axis_coincidence_reader #(
    parameter int unsigned DET_WIDTH   = 64,
    parameter int unsigned GROUPS      = 4,
    parameter int unsigned TIME_WIDTH  = 64,
    parameter int unsigned WIN_WIDTH   = 8,
    parameter int unsigned DEAD_WIDTH  = 16,
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic [DET_WIDTH-1:0]            det_data,
    input  logic [WIN_WIDTH-1:0]            cfg_window,
    input  logic [$clog2(GROUPS+1)-1:0]     cfg_threshold,
    input  logic [DEAD_WIDTH-1:0]           cfg_dead,
    output logic [TIME_WIDTH+DET_WIDTH-1:0] m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready
`ifdef LOST_CNTR_EN
    ,
    output logic [31:0]                     sts_lost
`endif
);

    localparam int unsigned SW = $clog2(GROUPS + 1);
    localparam int unsigned GW = DET_WIDTH / GROUPS;

    typedef enum logic [2:0] {
        StIdle,
        StWindow,
        StReduce,
        StCount,
        StDecide,
        StSend,
        StDead
    } state_e;

    logic [DET_WIDTH-1:0]  sync_q [SYNC_STAGES];
    logic [DET_WIDTH-1:0]  sync;
    logic                  sync_hit;
    logic [TIME_WIDTH-1:0] timer_q;

    state_e                state_q;
    logic [DET_WIDTH-1:0]  data_q;
    logic [TIME_WIDTH-1:0] ts_q;
    logic [WIN_WIDTH-1:0]  cnt_q;
    logic [WIN_WIDTH-1:0]  win_q;
    logic [WIN_WIDTH-1:0]  cnt_inc;
    logic [GROUPS-1:0]     grp_q;
    logic [GROUPS-1:0]     grp_or;
    logic [SW-1:0]         sum_q;
    logic [SW-1:0]         grp_sum;
    logic [DEAD_WIDTH-1:0] dead_q;
    logic                  tvalid_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= det_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync     = sync_q[SYNC_STAGES-1];
    assign sync_hit = |sync;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TIME_WIDTH'(1);
        end
    end

    assign cnt_inc = cnt_q + WIN_WIDTH'(1);

    always_comb begin
        grp_or = '0;
        for (int g = 0; g < GROUPS; g++) begin
            grp_or[g] = |data_q[g*GW +: GW];
        end
    end

    always_comb begin
        grp_sum = '0;
        for (int g = 0; g < GROUPS; g++) begin
            grp_sum = grp_sum + SW'(grp_q[g]);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= StIdle;
            data_q   <= '0;
            ts_q     <= '0;
            cnt_q    <= '0;
            win_q    <= '0;
            grp_q    <= '0;
            sum_q    <= '0;
            dead_q   <= '0;
            tvalid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    data_q <= sync;
                    if (sync_hit) begin
                        ts_q    <= timer_q;
                        cnt_q   <= '0;
                        win_q   <= cfg_window;
                        state_q <= (cfg_window != '0) ? StWindow : StReduce;
                    end
                end
                StWindow: begin
                    data_q <= data_q | sync;
                    cnt_q  <= cnt_inc;
                    if (cnt_inc == win_q) begin
                        state_q <= StReduce;
                    end
                end
                StReduce: begin
                    grp_q   <= grp_or;
                    state_q <= StCount;
                end
                StCount: begin
                    sum_q   <= grp_sum;
                    state_q <= StDecide;
                end
                StDecide: begin
                    if (sum_q >= cfg_threshold) begin
                        tvalid_q <= 1'b1;
                        state_q  <= StSend;
                    end else begin
                        dead_q  <= cfg_dead;
                        state_q <= StDead;
                    end
                end
                StSend: begin
                    if (m_axis_tready) begin
                        tvalid_q <= 1'b0;
                        dead_q   <= cfg_dead;
                        state_q  <= StDead;
                    end
                end
                StDead: begin
                    // A zero dead time still costs one cycle here.
                    if (dead_q <= DEAD_WIDTH'(1)) begin
                        state_q <= StIdle;
                    end else begin
                        dead_q <= dead_q - DEAD_WIDTH'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign m_axis_tdata  = {ts_q, data_q};
    assign m_axis_tvalid = tvalid_q;

`ifdef LOST_CNTR_EN
    logic [31:0] lost_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            lost_q <= '0;
        end else if ((state_q == StSend || state_q == StDead) && sync_hit && lost_q != '1) begin
            lost_q <= lost_q + 32'd1;
        end
    end

    assign sts_lost = lost_q;
`else
    // Lost-hit counter not built.
`endif

endmodule

// File: tb/tb_axis_coincidence_reader.sv
// Directed and randomized bench for axis_coincidence_reader against an event-level reference model.
module tb_axis_coincidence_reader;

    localparam int GW = 16;
    localparam int SS = 3;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [63:0]  det_data = '0;
    logic [7:0]   cfg_window = '0;
    logic [2:0]   cfg_threshold = '0;
    logic [15:0]  cfg_dead = '0;
    logic [127:0] tdata;
    logic         tvalid;
    logic         tready = 1'b0;
`ifdef LOST_CNTR_EN
    logic [31:0]  sts_lost;
`endif

    int vectors = 0;
    int miscompares = 0;
    int cyc;
    logic [63:0] pat [16];
    int pat_len;

    axis_coincidence_reader dut (
        .aclk          (aclk),
        .areset        (areset),
        .det_data      (det_data),
        .cfg_window    (cfg_window),
        .cfg_threshold (cfg_threshold),
        .cfg_dead      (cfg_dead),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready)
`ifdef LOST_CNTR_EN
        ,
        .sts_lost      (sts_lost)
`endif
    );

    always #5 aclk = ~aclk;

    // Cycles since reset release; equals the DUT timer between edges.
    always @(posedge aclk or posedge areset) begin
        if (areset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, summary expected earlier");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic quiet(input int n);
        det_data = '0;
        repeat (n) @(negedge aclk);
    endtask

    // Drives pat[0..pat_len-1] one vector per cycle and checks the resulting beat (or its absence).
    task automatic run_event(input int win, input int thr, input int dead, input int hold);
        logic [63:0]  exp_hits;
        logic [127:0] first;
        int ng;
        int c0;
        int t_exp;
        bit exp_beat;
        bit stable;
`ifdef LOST_CNTR_EN
        logic [31:0] lost0;
`endif
        cfg_window    = 8'(win);
        cfg_threshold = 3'(thr);
        cfg_dead      = 16'(dead);
        tready        = 1'b0;
        exp_hits = '0;
        for (int i = 0; i < pat_len; i++) begin
            if (i <= win) exp_hits |= pat[i];
        end
        ng = 0;
        for (int g = 0; g < 4; g++) begin
            if (exp_hits[g*GW +: GW] != '0) ng++;
        end
        exp_beat = (ng >= thr);
        c0 = cyc;
        t_exp = c0 + SS + win + 4;
        for (int i = 0; i < pat_len; i++) begin
            det_data = pat[i];
            @(negedge aclk);
        end
        det_data = '0;
        while (tvalid !== 1'b1 && cyc < t_exp + 6) @(negedge aclk);
        if (exp_beat) begin
            chk("beat_latency", 128'(cyc), 128'(t_exp));
            chk("beat_tdata", tdata, {64'(c0 + SS), exp_hits});
            first = tdata;
            stable = 1'b1;
`ifdef LOST_CNTR_EN
            lost0 = sts_lost;
`endif
            for (int k = 0; k < hold; k++) begin
`ifdef LOST_CNTR_EN
                if (hold >= 5) det_data = 64'h8;
`endif
                @(negedge aclk);
                if (tvalid !== 1'b1 || tdata !== first) stable = 1'b0;
            end
            det_data = '0;
            if (hold > 0) chk("hold_stable", 128'(stable), 128'(1));
            tready = 1'b1;
            @(negedge aclk);
            tready = 1'b0;
            chk("tvalid_drop", 128'(tvalid), 128'(0));
`ifdef LOST_CNTR_EN
            if (hold >= 5) chk("lost_rise", 128'(sts_lost > lost0), 128'(1));
`endif
        end else begin
            chk("no_beat", 128'(tvalid), 128'(0));
            if (tvalid === 1'b1) begin
                tready = 1'b1;
                @(negedge aclk);
                tready = 1'b0;
            end
        end
        quiet(dead + 5);
    endtask

    // Continuous hits with tready high: successive beats are window + pipeline + dead apart.
    task automatic spacing(input int win, input int dead);
        int t [3];
        int n;
        int exp_sp;
        t = '{0, 0, 0};
        n = 0;
        cfg_window    = 8'(win);
        cfg_dead      = 16'(dead);
        cfg_threshold = 3'd1;
        tready        = 1'b1;
        det_data      = 64'h1;
        for (int k = 0; k < 200 && n < 3; k++) begin
            @(negedge aclk);
            if (tvalid === 1'b1) begin
                t[n] = cyc;
                n++;
            end
        end
        exp_sp = win + 5 + ((dead == 0) ? 1 : dead);
        chk("spacing_1", 128'(t[1] - t[0]), 128'(exp_sp));
        chk("spacing_2", 128'(t[2] - t[1]), 128'(exp_sp));
        quiet(60);
        tready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge aclk);
        chk("reset_tvalid", 128'(tvalid), 128'(0));
        chk("reset_tdata", tdata, 128'(0));
        areset = 1'b0;
        quiet(3);

        // Single-cycle hit, window 3.
        pat[0] = 64'h1; pat_len = 1;
        run_event(3, 1, 2, 0);

        // Two hits inside a 4-cycle window, then the second outside a 2-cycle window.
        pat[0] = 64'h1; pat[1] = '0; pat[2] = 64'h1 << 20; pat_len = 3;
        run_event(3, 2, 2, 1);
        run_event(1, 2, 2, 0);

        // All four groups at once against thresholds 4, 5, then threshold 0.
        pat[0] = 64'h0001_0001_0001_0001; pat_len = 1;
        run_event(0, 4, 1, 0);
        run_event(2, 5, 1, 0);
        pat[0] = 64'h8000_0000_0000_0000;
        run_event(0, 0, 0, 2);

        // Long back-pressure hold.
        pat[0] = 64'h0000_0400_0000_0000; pat_len = 1;
        run_event(2, 1, 10, 20);

        spacing(2, 10);
        spacing(3, 0);

        // Reset while a beat is stalled.
        pat[0] = 64'h20; pat_len = 1;
        cfg_window = 8'd0; cfg_threshold = 3'd1; cfg_dead = 16'd3; tready = 1'b0;
        det_data = pat[0];
        @(negedge aclk);
        det_data = '0;
        for (int k = 0; k < 30 && tvalid !== 1'b1; k++) @(negedge aclk);
        chk("pre_reset_tvalid", 128'(tvalid), 128'(1));
        areset = 1'b1;
        #1;
        chk("async_reset_tvalid", 128'(tvalid), 128'(0));
        chk("async_reset_tdata", tdata, 128'(0));
        @(negedge aclk);
        areset = 1'b0;
        quiet(2);
        pat[0] = 64'h0000_0100_0000_0000; pat_len = 1;
        run_event(2, 1, 2, 0);

        // Randomized events checked against the event-level model.
        for (int e = 0; e < 30; e++) begin
            int w;
            int thr;
            int dead;
            int hold;
            w    = int'($urandom_range(0, 6));
            thr  = int'($urandom_range(0, 5));
            dead = int'($urandom_range(0, 8));
            hold = int'($urandom_range(0, 3));
            pat_len = int'($urandom_range(1, w + 4));
            for (int i = 0; i < pat_len; i++) begin
                case ($urandom_range(0, 3))
                    0:       pat[i] = '0;
                    1:       pat[i] = 64'h1 << $urandom_range(0, 63);
                    2:       pat[i] = (64'h1 << $urandom_range(0, 63)) | (64'h1 << $urandom_range(0, 63));
                    default: pat[i] = {$urandom, $urandom};
                endcase
            end
            pat[0] = pat[0] | (64'h1 << $urandom_range(0, 63));
            run_event(w, thr, dead, hold);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
